// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU and branch resolution into a registered EX/MEM slot.
// One-cycle latency; stall holds the slot, flush inserts a bubble and wins over stall.
package execute_stage_pkg;
  localparam int XLEN_P = 32;

  typedef struct packed {
    logic [3:0]        ALUControl;
    logic [1:0]        ALUSrcA;
    logic [1:0]        ALUSrcB;
    logic [XLEN_P-1:0] rd1;
    logic [XLEN_P-1:0] rd2;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN_P-1:0] imm_ext;
    logic [XLEN_P-1:0] pc_cur;
    logic              Branch;
    logic [2:0]        funct3;
    logic              RegWrite;
    logic              MemWrite;
    logic [1:0]        ResultSrc;
  } id_to_ex_t;

  typedef struct packed {
    logic [XLEN_P-1:0] alu_result;
    logic [XLEN_P-1:0] write_data;
    logic [4:0]        rd;
    logic              RegWrite;
    logic              MemWrite;
    logic [1:0]        ResultSrc;
    logic [2:0]        funct3;
    logic [XLEN_P-1:0] pc_plus4;
  } ex_to_mem_t;
endpackage

module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter int unsigned SQUASH_SLOTS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  id_to_ex_t       ID_to_EX,
  input  logic            id_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [4:0]      mem_rd,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [4:0]      wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_data,
  output ex_to_mem_t      EX_to_MEM,
  output logic            ex_valid,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_target
);

  logic [XLEN-1:0] fwd_a, fwd_b;
  logic [XLEN-1:0] alu_a, alu_b, alu_res;
  logic            br_cmp;
  logic            eff_valid;
  logic            taken;
  ex_to_mem_t      cap;

  ex_to_mem_t      ex_q, ex_d;
  logic            vld_q, vld_d;
  logic            redir_q, redir_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [1:0]      sq_q, sq_d;

  // MEM is younger than WB, so it wins; x0 is hardwired and never forwarded.
  always_comb begin
    fwd_a = ID_to_EX.rd1;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ID_to_EX.rs1))
      fwd_a = mem_result;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ID_to_EX.rs1))
      fwd_a = wb_data;
  end

  always_comb begin
    fwd_b = ID_to_EX.rd2;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ID_to_EX.rs2))
      fwd_b = mem_result;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ID_to_EX.rs2))
      fwd_b = wb_data;
  end

  always_comb begin
    alu_a = '0;
    case (ID_to_EX.ALUSrcA)
      2'b00:   alu_a = fwd_a;
      2'b01:   alu_a = ID_to_EX.pc_cur;
      default: alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (ID_to_EX.ALUSrcB)
      2'b00:   alu_b = fwd_b;
      2'b01:   alu_b = ID_to_EX.imm_ext;
      2'b10:   alu_b = XLEN'(4);
      default: alu_b = '0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (ID_to_EX.ALUControl)
      4'b0000: alu_res = alu_a + alu_b;
      4'b0001: alu_res = alu_a - alu_b;
      4'b0010: alu_res = alu_a & alu_b;
      4'b0011: alu_res = alu_a | alu_b;
      4'b0100: alu_res = alu_a ^ alu_b;
      4'b0101: alu_res = alu_a << alu_b[4:0];
      4'b0110: alu_res = alu_a >> alu_b[4:0];
      4'b0111: alu_res = $signed(alu_a) >>> alu_b[4:0];
      4'b1000: alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      4'b1001: alu_res = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_cmp = 1'b0;
    case (ID_to_EX.funct3)
      3'b000:  br_cmp = (fwd_a == fwd_b);
      3'b001:  br_cmp = (fwd_a != fwd_b);
      3'b100:  br_cmp = ($signed(fwd_a) <  $signed(fwd_b));
      3'b101:  br_cmp = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  br_cmp = (fwd_a <  fwd_b);
      3'b111:  br_cmp = (fwd_a >= fwd_b);
      default: br_cmp = 1'b0;
    endcase
  end

  // Instructions arriving in the shadow of a taken branch are wrong-path.
  assign eff_valid = id_valid && (sq_q == 2'd0);
  assign taken     = ID_to_EX.Branch && br_cmp && eff_valid;

  always_comb begin
    cap            = '0;
    cap.alu_result = alu_res;
    cap.write_data = fwd_b;
    cap.rd         = ID_to_EX.rd;
    cap.RegWrite   = ID_to_EX.RegWrite && eff_valid;
    cap.MemWrite   = ID_to_EX.MemWrite && eff_valid;
    cap.ResultSrc  = ID_to_EX.ResultSrc;
    cap.funct3     = ID_to_EX.funct3;
    cap.pc_plus4   = ID_to_EX.pc_cur + XLEN'(4);
  end

  always_comb begin
    ex_d    = ex_q;
    vld_d   = vld_q;
    redir_d = 1'b0;
    tgt_d   = tgt_q;
    sq_d    = sq_q;
    if (flush) begin
      ex_d          = cap;
      ex_d.RegWrite = 1'b0;
      ex_d.MemWrite = 1'b0;
      vld_d         = 1'b0;
      sq_d          = 2'd0;
    end else if (!stall) begin
      ex_d    = cap;
      vld_d   = eff_valid;
      redir_d = taken;
      if (taken) begin
        tgt_d = ID_to_EX.pc_cur + ID_to_EX.imm_ext;
        sq_d  = 2'(SQUASH_SLOTS);
      end else if (sq_q != 2'd0) begin
        sq_d = sq_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q    <= '0;
      vld_q   <= 1'b0;
      redir_q <= 1'b0;
      tgt_q   <= '0;
      sq_q    <= 2'd0;
    end else begin
      ex_q    <= ex_d;
      vld_q   <= vld_d;
      redir_q <= redir_d;
      tgt_q   <= tgt_d;
      sq_q    <= sq_d;
    end
  end

  assign EX_to_MEM       = ex_q;
  assign ex_valid        = vld_q;
  assign redirect        = redir_q;
  assign redirect_target = tgt_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed plus random stimulus for execute_stage against a behavioural reference model.
module tb_execute_stage;
  import execute_stage_pkg::*;

  localparam int SLOTS = 1;

  logic        clk = 1'b0;
  logic        reset;
  id_to_ex_t   ID_to_EX;
  logic        id_valid, stall, flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_data;
  ex_to_mem_t  EX_to_MEM;
  logic        ex_valid, redirect;
  logic [31:0] redirect_target;

  int checks   = 0;
  int failures = 0;

  // reference model state
  ex_to_mem_t  m_ex;
  logic        m_vld, m_redir;
  logic [31:0] m_tgt;
  int          m_sq;

  execute_stage #(.XLEN(32), .SQUASH_SLOTS(SLOTS)) dut (
    .clk(clk), .reset(reset), .ID_to_EX(ID_to_EX), .id_valid(id_valid),
    .stall(stall), .flush(flush), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .EX_to_MEM(EX_to_MEM), .ex_valid(ex_valid),
    .redirect(redirect), .redirect_target(redirect_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] regval);
    if (rs == 0) return regval;
    if (mem_reg_write && mem_rd == rs) return mem_result;
    if (wb_reg_write && wb_rd == rs) return wb_data;
    return regval;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return 32'($signed(a) >>> sh);
      4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) <  int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Predict the outcome of the next edge from the inputs currently driven, then compare.
  task automatic tick();
    logic [31:0] a, b, opa, opb;
    bit          valid, tk;
    ex_to_mem_t  snap;
    if (!reset) begin
      m_ex = '0; m_vld = 0; m_redir = 0; m_tgt = 0; m_sq = 0;
    end else begin
      a     = operand(ID_to_EX.rs1, ID_to_EX.rd1);
      b     = operand(ID_to_EX.rs2, ID_to_EX.rd2);
      opa   = (ID_to_EX.ALUSrcA == 0) ? a : (ID_to_EX.ALUSrcA == 1) ? ID_to_EX.pc_cur : 32'd0;
      opb   = (ID_to_EX.ALUSrcB == 0) ? b : (ID_to_EX.ALUSrcB == 1) ? ID_to_EX.imm_ext :
              (ID_to_EX.ALUSrcB == 2) ? 32'd4 : 32'd0;
      valid = id_valid && (m_sq == 0);
      tk    = ID_to_EX.Branch && ref_branch(ID_to_EX.funct3, a, b) && valid;
      snap.alu_result = ref_alu(ID_to_EX.ALUControl, opa, opb);
      snap.write_data = b;
      snap.rd         = ID_to_EX.rd;
      snap.RegWrite   = ID_to_EX.RegWrite && valid;
      snap.MemWrite   = ID_to_EX.MemWrite && valid;
      snap.ResultSrc  = ID_to_EX.ResultSrc;
      snap.funct3     = ID_to_EX.funct3;
      snap.pc_plus4   = ID_to_EX.pc_cur + 32'd4;
      if (flush) begin
        m_ex = snap; m_ex.RegWrite = 0; m_ex.MemWrite = 0;
        m_vld = 0; m_redir = 0; m_sq = 0;
      end else if (stall) begin
        m_redir = 0;
      end else begin
        m_ex = snap; m_vld = valid; m_redir = tk;
        if (tk) begin
          m_tgt = ID_to_EX.pc_cur + ID_to_EX.imm_ext;
          m_sq  = SLOTS;
        end else if (m_sq > 0) begin
          m_sq = m_sq - 1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("ex_to_mem", 128'(EX_to_MEM), 128'(m_ex));
    chk("ex_valid", 128'(ex_valid), 128'(m_vld));
    chk("redirect", 128'(redirect), 128'(m_redir));
    chk("redirect_target", 128'(redirect_target), 128'(m_tgt));
  endtask

  task automatic idle();
    ID_to_EX = '0; id_valid = 0; stall = 0; flush = 0;
    mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_data = 0;
  endtask

  initial begin
    reset = 0;
    idle();
    tick();
    chk("reset_ex", 128'(EX_to_MEM), 128'd0);
    chk("reset_tgt", 128'(redirect_target), 128'd0);
    reset = 1;

    // ADD without hazards
    idle();
    ID_to_EX.rd1 = 5; ID_to_EX.rd2 = 7; ID_to_EX.rs1 = 1; ID_to_EX.rs2 = 2;
    ID_to_EX.rd = 4; ID_to_EX.RegWrite = 1; id_valid = 1;
    tick();
    chk("add_result", 128'(EX_to_MEM.alu_result), 128'd12);
    chk("add_valid", 128'(ex_valid), 128'd1);
    chk("add_regwrite", 128'(EX_to_MEM.RegWrite), 128'd1);

    // forwarding priority, then x0 never forwarded
    ID_to_EX.rs1 = 3; ID_to_EX.rd1 = 32'h99; ID_to_EX.rs2 = 0; ID_to_EX.rd2 = 1;
    mem_rd = 3; mem_reg_write = 1; mem_result = 32'h10;
    wb_rd = 3; wb_reg_write = 1; wb_data = 32'h20;
    tick();
    chk("fwd_mem_prio", 128'(EX_to_MEM.alu_result), 128'h11);
    ID_to_EX.rs1 = 0; ID_to_EX.rd1 = 32'h55; mem_rd = 0; wb_rd = 0;
    tick();
    chk("fwd_x0", 128'(EX_to_MEM.alu_result), 128'h56);

    // taken BNE, one squashed slot, then normal capture
    idle();
    ID_to_EX.pc_cur = 32'h100; ID_to_EX.imm_ext = 32'hFFFF_FFF0;
    ID_to_EX.rd1 = 1; ID_to_EX.rd2 = 2; ID_to_EX.rs1 = 1; ID_to_EX.rs2 = 2;
    ID_to_EX.Branch = 1; ID_to_EX.funct3 = 3'b001; id_valid = 1;
    tick();
    chk("bne_redirect", 128'(redirect), 128'd1);
    chk("bne_target", 128'(redirect_target), 128'hF0);
    idle();
    ID_to_EX.RegWrite = 1; ID_to_EX.rd = 6; id_valid = 1;
    tick();
    chk("shadow_valid", 128'(ex_valid), 128'd0);
    chk("shadow_regwrite", 128'(EX_to_MEM.RegWrite), 128'd0);
    chk("bne_pulse_once", 128'(redirect), 128'd0);
    tick();
    chk("after_shadow_valid", 128'(ex_valid), 128'd1);

    // SUB then stall for 3 cycles
    idle();
    ID_to_EX.ALUControl = 4'b0001; ID_to_EX.rd1 = 9; ID_to_EX.rd2 = 4;
    ID_to_EX.RegWrite = 1; id_valid = 1;
    tick();
    ID_to_EX.rd1 = 100; stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_result", 128'(EX_to_MEM.alu_result), 128'd5);
      chk("stall_valid", 128'(ex_valid), 128'd1);
    end
    stall = 0;

    // taken BEQ held by stall: single redirect pulse
    idle();
    ID_to_EX.rd1 = 7; ID_to_EX.rd2 = 7; ID_to_EX.Branch = 1; ID_to_EX.funct3 = 3'b000;
    ID_to_EX.pc_cur = 32'h200; ID_to_EX.imm_ext = 32'h40; id_valid = 1;
    tick();
    chk("beq_redirect", 128'(redirect), 128'd1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_no_redirect", 128'(redirect), 128'd0);
    end
    stall = 0;
    tick();
    chk("second_branch_squashed", 128'(redirect), 128'd0);

    // flush beats stall on a store
    idle();
    ID_to_EX.MemWrite = 1; id_valid = 1; stall = 1; flush = 1;
    tick();
    chk("flush_valid", 128'(ex_valid), 128'd0);
    chk("flush_memwrite", 128'(EX_to_MEM.MemWrite), 128'd0);

    // reset mid-squash
    idle();
    ID_to_EX.rd1 = 3; ID_to_EX.rd2 = 3; ID_to_EX.Branch = 1; ID_to_EX.pc_cur = 32'h300;
    ID_to_EX.imm_ext = 32'h8; ID_to_EX.RegWrite = 1; id_valid = 1;
    tick();
    reset = 0;
    tick();
    chk("midsquash_reset_ex", 128'(EX_to_MEM), 128'd0);
    chk("midsquash_reset_tgt", 128'(redirect_target), 128'd0);
    reset = 1;
    idle();
    ID_to_EX.RegWrite = 1; ID_to_EX.rd1 = 2; id_valid = 1;
    tick();
    chk("post_reset_not_squashed", 128'(ex_valid), 128'd1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      ID_to_EX = id_to_ex_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      ID_to_EX.rs1 = 5'($urandom_range(0, 3));
      ID_to_EX.rs2 = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ID_to_EX.rd2 = ID_to_EX.rd1;
      ID_to_EX.Branch = ($urandom_range(0, 2) == 0);
      id_valid      = ($urandom_range(0, 4) != 0);
      stall         = ($urandom_range(0, 5) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      reset         = ($urandom_range(0, 39) != 0);
      mem_rd        = 5'($urandom_range(0, 3));
      wb_rd         = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom);
      wb_reg_write  = 1'($urandom);
      mem_result    = $urandom;
      wb_data       = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Consumer end of the id_to_ex_t pipeline interface.
- Takes the ID/EX register contents and resolves operands through forwarding from MEM and WB.
- Computes the ALU result and resolves conditional branches.
- Captures everything into a registered EX/MEM output with stall, flush and valid handling; issues a registered PC redirect to fetch on a taken branch.

Parameters:
XLEN, 32, datapath width
SQUASH_SLOTS, 1, number of incoming instructions squashed internally after a taken branch (0 to 3)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
ID_to_EX  input  id_to_ex_t  fields used: ALUControl, ALUSrcA, ALUSrcB, rd1, rd2, rs1, rs2, rd, imm_ext, pc_cur, Branch, funct3, RegWrite, MemWrite, ResultSrc
id_valid  input  1  ID_to_EX holds a real instruction
stall  input  1  hold the output register
flush  input  1  insert a bubble into the output register
mem_rd  input  5  destination register of the instruction in MEM
mem_reg_write  input  1  MEM instruction writes the register file
mem_result  input  XLEN  MEM forwarding value
wb_rd  input  5  destination register of the instruction in WB
wb_reg_write  input  1  WB instruction writes the register file
wb_data  input  XLEN  WB forwarding value
EX_to_MEM  output  ex_to_mem_t  fields: alu_result, write_data, rd, RegWrite, MemWrite, ResultSrc, funct3, pc_plus4
ex_valid  output  1  EX_to_MEM holds a real instruction
redirect  output  1  one-cycle pulse: branch taken
redirect_target  output  XLEN  branch target PC

Behaviour:
- Reset (reset==0 at posedge clk):
  - All EX_to_MEM fields = 0; ex_valid = 0; redirect = 0; redirect_target = 0; squash counter = 0.
- Forwarding, operand A (combinational):
  - If mem_reg_write && mem_rd != 0 && mem_rd == rs1, use mem_result.
  - Else if wb_reg_write && wb_rd != 0 && wb_rd == rs1, use wb_data.
  - Else use rd1.
  - MEM has priority over WB. x0 is never forwarded.
- Forwarding, operand B: same rules using rs2 and rd2. The forwarded B value also drives write_data.
- ALU operand select:
  - ALUSrcA: 00 = fwd A, 01 = pc_cur, 10 = 0.
  - ALUSrcB: 00 = fwd B, 01 = imm_ext, 10 = 4.
  - Code 11 on either selects 0.
- ALUControl encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA: shift amount = B[4:0].
  - 1000 SLT (signed), 1001 SLTU: result 0 or 1.
  - Others: result 0.
  - Arithmetic wraps modulo 2^XLEN.
- Branch compare (fwd A vs fwd B, by funct3):
  - 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - 010 and 011: never taken.
- taken = Branch && compare && effective valid, where effective valid = id_valid && squash counter == 0.
- Latency: one cycle. ID_to_EX sampled at posedge N appears on EX_to_MEM, ex_valid and redirect after posedge N.
- Normal cycle (no stall, no flush):
  - EX_to_MEM captures alu_result, write_data, rd, RegWrite, MemWrite, ResultSrc, funct3, pc_plus4 = pc_cur + 4.
  - ex_valid = effective valid.
  - When the captured instruction is not effectively valid, the RegWrite and MemWrite fields are forced to 0.
  - redirect = taken; redirect_target = pc_cur + imm_ext, updated only when taken.
- Squash counter:
  - Loads SQUASH_SLOTS on a captured taken branch.
  - Decrements by 1 on each subsequent non-stalled cycle while nonzero.
  - While nonzero, incoming instructions are treated as invalid.
- stall==1:
  - EX_to_MEM, ex_valid and the squash counter hold their values.
  - redirect is forced to 0, so a redirect pulse never repeats.
- flush==1:
  - ex_valid = 0; RegWrite and MemWrite fields = 0; redirect = 0.
  - Squash counter cleared to 0.
  - flush has priority over stall.
- Back-to-back taken branches: the second branch is squashed while the counter is nonzero and generates no redirect.
- Reset mid-stall or mid-squash returns every register to its reset value on that edge.

Test Plan:
- ADD, no hazards: rd1=5, rd2=7, ALUSrcB=00, id_valid=1 -> next cycle alu_result=12, ex_valid=1, RegWrite=1.
- Forwarding priority: rs1=3, mem_rd=3 with mem_result=0x10, wb_rd=3 with wb_data=0x20, rd2=1, ADD -> alu_result=0x11. Repeat with rs1=0 -> alu_result = rd1+1.
- Taken BNE: pc_cur=0x100, imm_ext=0xFFFFFFF0, operands 1 vs 2 -> redirect=1 for exactly one cycle, redirect_target=0xF0. Next instruction (id_valid=1, RegWrite=1) -> ex_valid=0, RegWrite=0. The instruction after that is captured normally.
- Stall hold: stall=1 for 3 cycles after a captured SUB (9-4=5) -> alu_result stays 5, ex_valid stays 1, redirect stays 0. Same scenario with a taken branch -> redirect pulses only once.
- Flush wins: stall=1 and flush=1 together while a valid store is presented -> ex_valid=0, MemWrite=0.
- Reset: drive reset=0 mid-squash with outputs nonzero -> all outputs 0 after the edge. First instruction after reset=1 is not squashed.
